// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Hazard and sequencing controller for the 5-stage pipeline. Produces the
// pipeline-register write enables plus the IF/ID flush and ID/EX bubble
// controls. Handles load-use stalls, branch/jump redirects, data-memory wait
// freezes with a timeout into HALT, and an explicit halt/resume state.
//
// Optional feature: define HAZARD_PERF_EN to build the saturating stall and
// redirect performance counters; otherwise stall_cnt/flush_cnt are tied to 0.
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rt,
   input  logic             ex_mem_read,
   input  logic [4:0]       ex_rd,
   input  logic             ex_branch_taken,
   input  logic             ex_jump,
   input  logic             mem_busy,
   input  logic             halt_req,
   input  logic             resume,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             idex_write,
   output logic             idex_bubble,
   output logic             exmem_write,
   output logic             halted,
   output logic             mem_timeout_err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      HALT     = 2'd2
   } state_t;

   // Wait counter holds 1..MEM_TIMEOUT-1 while in MEM_WAIT.
   localparam int            WAIT_W   = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

   state_t            state;
   logic [WAIT_W-1:0] waitCnt;
   logic              memTimeoutErr;

   logic redirect;
   logic loadUse;
   logic isRedirectCycle;

   logic pcWrite;
   logic ifidWrite;
   logic ifidFlush;
   logic idexWrite;
   logic idexBubble;
   logic exmemWrite;

   assign redirect = ex_branch_taken | ex_jump;

   // A load in EX whose destination is read by the ID instruction; r0 never hazards.
   assign loadUse = ex_mem_read && (ex_rd != 5'd0) &&
                    ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

   // Mealy pipeline controls from current state and current inputs.
   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      pcWrite         = 1'b0;
      ifidWrite       = 1'b0;
      ifidFlush       = 1'b0;
      idexWrite       = 1'b0;
      idexBubble      = 1'b0;
      exmemWrite      = 1'b0;
      isRedirectCycle = 1'b0;
      if (rst) begin
         // Hold everything and keep NOPs flowing into IF/ID and ID/EX.
         ifidFlush  = 1'b1;
         idexBubble = 1'b1;
      end else if (state == HALT || mem_busy) begin
         // Full freeze: nothing advances, nothing is cleared.
      end else if (redirect) begin
         // Wrong-path instruction in ID is discarded, so any load-use is moot.
         pcWrite         = 1'b1;
         ifidWrite       = 1'b1;
         ifidFlush       = 1'b1;
         idexWrite       = 1'b1;
         idexBubble      = 1'b1;
         exmemWrite      = 1'b1;
         isRedirectCycle = 1'b1;
      end else if (loadUse) begin
         // Hold PC and IF/ID, let the load advance with a bubble behind it.
         idexWrite  = 1'b1;
         idexBubble = 1'b1;
         exmemWrite = 1'b1;
      end else begin
         pcWrite    = 1'b1;
         ifidWrite  = 1'b1;
         idexWrite  = 1'b1;
         exmemWrite = 1'b1;
      end
   end

   // Sequencing FSM: memory-wait tracking with timeout, halt and resume.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         state         <= RUN;
         waitCnt       <= '0;
         memTimeoutErr <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (mem_busy) begin
                  if (MEM_TIMEOUT <= 1) begin
                     state         <= HALT;
                     waitCnt       <= '0;
                     memTimeoutErr <= 1'b1;
                  end else begin
                     state   <= MEM_WAIT;
                     waitCnt <= WAIT_ONE;
                  end
               end else if (halt_req) begin
                  state <= HALT;
               end
            end
            MEM_WAIT: begin
               if (!mem_busy) begin
                  state   <= RUN;
                  waitCnt <= '0;
               end else if (waitCnt >= WAIT_LAST) begin
                  // This busy cycle brings the count to MEM_TIMEOUT.
                  state         <= HALT;
                  waitCnt       <= '0;
                  memTimeoutErr <= 1'b1;
               end else begin
                  waitCnt <= waitCnt + WAIT_ONE;
               end
            end
            HALT: begin
               if (resume) begin
                  state <= RUN;
               end
            end
            default: begin
               state   <= RUN;
               waitCnt <= '0;
            end
         endcase
      end
   end

`ifdef HAZARD_PERF_EN
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [CNT_W-1:0] stallCnt;
   logic [CNT_W-1:0] flushCnt;

   // Saturating perf counters: cycles without a PC load, and redirect cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stallCnt <= '0;
         flushCnt <= '0;
      end else begin
         if (!pcWrite && (stallCnt != '1)) begin
            stallCnt <= stallCnt + CNT_ONE;
         end
         if (isRedirectCycle && (flushCnt != '1)) begin
            flushCnt <= flushCnt + CNT_ONE;
         end
      end
   end

   assign stall_cnt = stallCnt;
   assign flush_cnt = flushCnt;
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

   assign pc_write        = pcWrite;
   assign ifid_write      = ifidWrite;
   assign ifid_flush      = ifidFlush;
   assign idex_write      = idexWrite;
   assign idex_bubble     = idexBubble;
   assign exmem_write     = exmemWrite;
   assign halted          = (state == HALT) && !rst;
   assign mem_timeout_err = memTimeoutErr;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
// Scoreboard bench: the driver applies one input vector per cycle, asks a
// rule-level model for the expected outputs and queues them; the monitor pops
// one expectation per cycle at the falling edge and compares.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

   localparam int MEM_TIMEOUT = 4;
   localparam int CNT_W       = 5;
   localparam int CNT_MAX     = (1 << CNT_W) - 1;

   typedef struct packed {
      logic             pcW;
      logic             ifidW;
      logic             ifidF;
      logic             idexW;
      logic             idexB;
      logic             exmemW;
      logic             halted;
      logic             err;
      logic [CNT_W-1:0] stall;
      logic [CNT_W-1:0] flush;
   } obs_t;

   typedef struct {
      string tag;
      obs_t  exp;
   } item_t;

   typedef struct packed {
      logic       rst;
      logic [4:0] rs;
      logic [4:0] rt;
      logic       usesRt;
      logic       memRead;
      logic [4:0] rd;
      logic       br;
      logic       jmp;
      logic       busy;
      logic       haltReq;
      logic       resume;
   } stim_t;

   logic             clk;
   logic             rst;
   logic [4:0]       id_rs;
   logic [4:0]       id_rt;
   logic             id_uses_rt;
   logic             ex_mem_read;
   logic [4:0]       ex_rd;
   logic             ex_branch_taken;
   logic             ex_jump;
   logic             mem_busy;
   logic             halt_req;
   logic             resume;
   logic             pc_write;
   logic             ifid_write;
   logic             ifid_flush;
   logic             idex_write;
   logic             idex_bubble;
   logic             exmem_write;
   logic             halted;
   logic             mem_timeout_err;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   pipeline_hazard_ctrl #(
      .MEM_TIMEOUT(MEM_TIMEOUT),
      .CNT_W      (CNT_W)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .id_rs          (id_rs),
      .id_rt          (id_rt),
      .id_uses_rt     (id_uses_rt),
      .ex_mem_read    (ex_mem_read),
      .ex_rd          (ex_rd),
      .ex_branch_taken(ex_branch_taken),
      .ex_jump        (ex_jump),
      .mem_busy       (mem_busy),
      .halt_req       (halt_req),
      .resume         (resume),
      .pc_write       (pc_write),
      .ifid_write     (ifid_write),
      .ifid_flush     (ifid_flush),
      .idex_write     (idex_write),
      .idex_bubble    (idex_bubble),
      .exmem_write    (exmem_write),
      .halted         (halted),
      .mem_timeout_err(mem_timeout_err),
      .stall_cnt      (stall_cnt),
      .flush_cnt      (flush_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int    errors = 0;
   int    checks = 0;
   item_t sb[$];

   // Reference model state: is the pipeline halted, how many consecutive
   // busy cycles have been seen, the sticky timeout flag, and perf counts.
   bit    mHalted;
   int    mBusyRun;
   bit    mErr;
   int    mStall;
   int    mFlush;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   function automatic stim_t idle();
      stim_t s;
      s = '0;
      return s;
   endfunction

   // Apply one cycle of stimulus and queue the expected response.
   task automatic cyc(input stim_t s, input string tag);
      obs_t  e;
      bit    redir;
      bit    hazard;
      item_t it;
      @(posedge clk);
      #1;
      rst             = s.rst;
      id_rs           = s.rs;
      id_rt           = s.rt;
      id_uses_rt      = s.usesRt;
      ex_mem_read     = s.memRead;
      ex_rd           = s.rd;
      ex_branch_taken = s.br;
      ex_jump         = s.jmp;
      mem_busy        = s.busy;
      halt_req        = s.haltReq;
      resume          = s.resume;

      e     = '0;
      redir = 1'b0;
      if (s.rst) begin
         mHalted  = 1'b0;
         mBusyRun = 0;
         mErr     = 1'b0;
         mStall   = 0;
         mFlush   = 0;
         e.ifidF  = 1'b1;
         e.idexB  = 1'b1;
      end else begin
         e.err = mErr;
`ifdef HAZARD_PERF_EN
         e.stall = CNT_W'(mStall);
         e.flush = CNT_W'(mFlush);
`endif
         if (mHalted) begin
            e.halted = 1'b1;
            if (s.resume) mHalted = 1'b0;
         end else if (s.busy) begin
            mBusyRun++;
            if (mBusyRun >= MEM_TIMEOUT) begin
               mHalted  = 1'b1;
               mErr     = 1'b1;
               mBusyRun = 0;
            end
         end else begin
            hazard = s.memRead && (s.rd != 0) &&
                     ((s.rd == s.rs) || (s.usesRt && (s.rd == s.rt)));
            if (s.br || s.jmp) begin
               {e.pcW, e.ifidW, e.ifidF, e.idexW, e.idexB, e.exmemW} = 6'b111111;
               redir = 1'b1;
            end else if (hazard) begin
               {e.idexW, e.idexB, e.exmemW} = 3'b111;
            end else begin
               {e.pcW, e.ifidW, e.idexW, e.exmemW} = 4'b1111;
            end
            // A halt request counts only when no memory wait was in progress.
            if (s.haltReq && mBusyRun == 0) mHalted = 1'b1;
            mBusyRun = 0;
         end
         if (!e.pcW && mStall < CNT_MAX) mStall++;
         if (redir && mFlush < CNT_MAX) mFlush++;
      end
      it.tag = tag;
      it.exp = e;
      sb.push_back(it);
   endtask

   // Monitor: one expectation per cycle, sampled mid-cycle.
   initial begin
      item_t it;
      obs_t  a;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            it = sb.pop_front();
            a  = {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble,
                  exmem_write, halted, mem_timeout_err, stall_cnt, flush_cnt};
            check(it.tag, 64'(a), 64'(it.exp));
         end
      end
   end

   initial begin
      stim_t s;
      rst = 1'b1;
      {id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rd} = '0;
      {ex_branch_taken, ex_jump, mem_busy, halt_req, resume} = '0;

      // Reset state
      s = idle(); s.rst = 1'b1;
      cyc(s, "reset0");
      cyc(s, "reset1");

      // Load-use on rs: one stall cycle, then normal flow
      s = idle(); s.memRead = 1'b1; s.rd = 5'd5; s.rs = 5'd5;
      cyc(s, "loaduse_rs");
      s = idle();
      cyc(s, "after_loaduse");

      // r0 never hazards; rt match ignored when rt is not read; rt match when read
      s = idle(); s.memRead = 1'b1; s.rd = 5'd0; s.rs = 5'd0;
      cyc(s, "rd_zero");
      s = idle(); s.memRead = 1'b1; s.rd = 5'd7; s.rt = 5'd7; s.usesRt = 1'b0;
      cyc(s, "rt_unused");
      s.usesRt = 1'b1;
      cyc(s, "loaduse_rt");

      // Taken branch overrides coincident load-use
      s = idle(); s.br = 1'b1; s.memRead = 1'b1; s.rd = 5'd3; s.rs = 5'd3;
      cyc(s, "branch_over_loaduse");

      // Memory wait with jump held: three freezes, then redirect
      s = idle(); s.jmp = 1'b1; s.busy = 1'b1;
      repeat (3) cyc(s, "busy_jump_freeze");
      s.busy = 1'b0;
      cyc(s, "jump_after_wait");

      // Timeout into HALT, resume, sticky error
      s = idle(); s.busy = 1'b1;
      repeat (MEM_TIMEOUT) cyc(s, "busy_to_timeout");
      s.br = 1'b1;
      repeat (3) cyc(s, "halted_freeze");
      s = idle(); s.resume = 1'b1;
      cyc(s, "resume");
      s = idle();
      cyc(s, "run_err_sticky");

      // halt_req during memory wait is ignored
      s = idle(); s.busy = 1'b1;
      cyc(s, "wait_enter");
      s = idle(); s.haltReq = 1'b1;
      cyc(s, "wait_exit_haltreq");
      s = idle();
      cyc(s, "still_run");

      // halt_req in RUN: run outputs now, HALT next; long halt saturates stall count
      s = idle(); s.haltReq = 1'b1; s.jmp = 1'b1;
      cyc(s, "haltreq_run");
      s = idle();
      repeat (40) cyc(s, "long_halt");
      s.resume = 1'b1;
      cyc(s, "resume2");
      s = idle();
      cyc(s, "run_again");

      // Reset asserted while in MEM_WAIT
      s = idle(); s.busy = 1'b1;
      repeat (2) cyc(s, "wait_before_rst");
      s.rst = 1'b1;
      cyc(s, "rst_in_wait");
      s = idle();
      cyc(s, "after_rst");

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         s.rst     = ($urandom_range(0, 99) < 1);
         s.rs      = 5'($urandom_range(0, 3));
         s.rt      = 5'($urandom_range(0, 3));
         s.usesRt  = 1'($urandom);
         s.memRead = ($urandom_range(0, 99) < 40);
         s.rd      = 5'($urandom_range(0, 3));
         s.br      = ($urandom_range(0, 99) < 15);
         s.jmp     = ($urandom_range(0, 99) < 5);
         s.busy    = ($urandom_range(0, 99) < 25);
         s.haltReq = ($urandom_range(0, 99) < 5);
         s.resume  = ($urandom_range(0, 99) < 20);
         cyc(s, "random");
      end

      repeat (3) @(posedge clk);
      check("scoreboard_drained", 64'(sb.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
